// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - RV32I instruction fetch stage with IF/ID pipeline register
//
// Owns the PC and keeps at most one request outstanding to instruction memory.
// It delivers {instruction, pc, pc+4, valid} to decode. It supports hazard
// stall, redirect with flush, and dropping of stale memory responses.
//
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_killed counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req, imem_addr       request valid and word-aligned fetch address
//   imem_gnt                  memory accepted the request
//   imem_rvalid, imem_rdata   response valid and fetched instruction
//   stall_i                   hold IF/ID and PC
//   redirect_i, redirect_pc_i taken branch/jump and its target
//   if_id_*                   registered IF/ID contents for decode
//   perf_fetched, perf_killed (FETCH_PERF_CNT_EN only) event counters
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  if_id_valid,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [DATA_WIDTH-1:0] if_id_pc,
  output logic [DATA_WIDTH-1:0] if_id_pc4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_killed
`endif
);

  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));
  localparam logic [DATA_WIDTH-1:0] FOUR       = DATA_WIDTH'(4);

  state_t                state, state_next;
  logic                  kill, kill_next;
  logic [DATA_WIDTH-1:0] pc, pc_next;
  logic [DATA_WIDTH-1:0] hold_instr, hold_pc;
  logic                  flush, load_mem, load_hold, capture;

  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc & ALIGN_MASK;

  always_comb begin
    state_next = state;
    kill_next  = kill;
    pc_next    = pc;
    flush      = 1'b0;
    load_mem   = 1'b0;
    load_hold  = 1'b0;
    capture    = 1'b0;
    if (redirect_i) begin
      // Redirect beats stall. An outstanding request is still waited for,
      // but its response is marked for discard through kill.
      flush   = 1'b1;
      pc_next = redirect_pc_i & ALIGN_MASK;
      case (state)
        FETCH: if (imem_gnt) begin
          state_next = WAIT;
          kill_next  = 1'b1;
        end
        WAIT: if (imem_rvalid) begin
          state_next = FETCH;
          kill_next  = 1'b0;
        end else begin
          kill_next  = 1'b1;
        end
        HOLD:    state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: if (imem_gnt) begin
          state_next = WAIT;
          kill_next  = 1'b0;
        end
        WAIT: if (imem_rvalid) begin
          if (kill) begin
            // PC already points at the redirect target.
            state_next = FETCH;
            kill_next  = 1'b0;
          end else if (!stall_i) begin
            load_mem   = 1'b1;
            pc_next    = pc + FOUR;
            state_next = FETCH;
          end else begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end
        HOLD: if (!stall_i) begin
          load_hold  = 1'b1;
          pc_next    = pc + FOUR;
          state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      kill  <= 1'b0;
      pc    <= RESET_PC[DATA_WIDTH-1:0];
    end else begin
      state <= state_next;
      kill  <= kill_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid       <= 1'b0;
      if_id_instruction <= NOP_INSTR[DATA_WIDTH-1:0];
      if_id_pc          <= '0;
      if_id_pc4         <= '0;
      hold_instr        <= '0;
      hold_pc           <= '0;
    end else begin
      if (capture) begin
        hold_instr <= imem_rdata;
        hold_pc    <= pc;
      end
      if (flush) begin
        if_id_valid       <= 1'b0;
        if_id_instruction <= NOP_INSTR[DATA_WIDTH-1:0];
        if_id_pc          <= '0;
        if_id_pc4         <= '0;
      end else if (load_mem) begin
        if_id_valid       <= 1'b1;
        if_id_instruction <= imem_rdata;
        if_id_pc          <= pc;
        if_id_pc4         <= pc + FOUR;
      end else if (load_hold) begin
        if_id_valid       <= 1'b1;
        if_id_instruction <= hold_instr;
        if_id_pc          <= hold_pc;
        if_id_pc4         <= hold_pc + FOUR;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // A response is dropped when it arrives while kill is set or during a redirect.
  logic resp_dropped;
  assign resp_dropped = (state == WAIT) && imem_rvalid && (kill || redirect_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
    end else begin
      if (load_mem || load_hold) perf_fetched <= perf_fetched + 32'd1;
      if (resp_dropped)          perf_killed  <= perf_killed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - directed self-checking bench for if_id_fetch_stage
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  if_id_fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_gnt          (imem_gnt),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc4         (if_id_pc4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_killed       (perf_killed)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] pc4);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    check({tag, ".instr"}, if_id_instruction, ins);
    check({tag, ".pc"}, if_id_pc, pc);
    check({tag, ".pc4"}, if_id_pc4, pc4);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr);
    check({tag, ".req"}, 32'(imem_req), 32'd1);
    check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    step(); step();
    ifid("reset", 1'b0, NOP, 32'h0, 32'h0);
    check("reset.req", 32'(imem_req), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("reset.perf_fetched", perf_fetched, 32'd0);
    check("reset.perf_killed", perf_killed, 32'd0);
`endif
    rst = 1'b0; #1;
    fetch("f0", 32'h0);

    // Back-to-back fetches at 0 and 4.
    imem_gnt = 1'b1; step();
    check("wait0.req", 32'(imem_req), 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00500093; step();
    ifid("ld0", 1'b1, 32'h00500093, 32'h0, 32'h4);
    fetch("f4", 32'h4);
    imem_rvalid = 1'b0; imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A00113; step();
    ifid("ld4", 1'b1, 32'h00A00113, 32'h4, 32'h8);
    fetch("f8", 32'h8);

    // Stall while the response at 8 arrives.
    imem_rvalid = 1'b0; imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; stall_i = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h00000013; step();
    ifid("hold", 1'b1, 32'h00A00113, 32'h4, 32'h8);
    check("hold.req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF; step();
    ifid("hold2", 1'b1, 32'h00A00113, 32'h4, 32'h8);
    stall_i = 1'b0; step();
    ifid("release", 1'b1, 32'h00000013, 32'h8, 32'hC);
    fetch("f12", 32'hC);

    // Redirect while waiting; the late response is stale.
    imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; step();
    ifid("flush_wait", 1'b0, NOP, 32'h0, 32'h0);
    check("flush_wait.req", 32'(imem_req), 32'd0);
    redirect_i = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; step();
    ifid("stale_drop", 1'b0, NOP, 32'h0, 32'h0);
    fetch("f100", 32'h100);

    // Load 0x100, then park 0x104 in HOLD and redirect with stall held.
    imem_rvalid = 1'b0; imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00100093; step();
    ifid("ld100", 1'b1, 32'h00100093, 32'h100, 32'h104);
    imem_rvalid = 1'b0; imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; stall_i = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h00200113; step();
    ifid("hold104", 1'b1, 32'h00100093, 32'h100, 32'h104);
    imem_rvalid = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; step();
    ifid("flush_hold", 1'b0, NOP, 32'h0, 32'h0);
    fetch("ftop", 32'hFFFF_FFFC);

    // PC wrap.
    redirect_i = 1'b0; stall_i = 1'b0; imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00300193; step();
    ifid("wrap", 1'b1, 32'h00300193, 32'hFFFF_FFFC, 32'h0);
    fetch("fwrap", 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd5);
    check("perf_killed", perf_killed, 32'd1);
`endif

    // Reset in WAIT with a response in the same cycle, and one the cycle after.
    imem_rvalid = 1'b0; imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000ABCD; step();
    ifid("rst_wait", 1'b0, NOP, 32'h0, 32'h0);
    check("rst_wait.req", 32'(imem_req), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst.perf_fetched", perf_fetched, 32'd0);
    check("rst.perf_killed", perf_killed, 32'd0);
`endif
    rst = 1'b0; step();
    ifid("post_rst", 1'b0, NOP, 32'h0, 32'h0);
    fetch("f_post", 32'h0);
    imem_rvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
